// File: rtl/seq_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seq_addsub_pkg
// Description : Shared types for the multi-cycle adder/subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package seq_addsub_pkg;

   // Controller states; values are fixed so debug dumps stay stable.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : seq_addsub_pkg
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module      : addsub_slice
// Description : Combinational CHUNK-bit adder with carry-in, carry-out and
//               sum MSB. One instance is reused for every slice of an operation.
// Revision    : 1.0 - initial release
// ============================================================================
module addsub_slice #(
   parameter int CHUNK = 4
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_sum_msb
);

   logic [CHUNK:0] w_full;

   // Widen by one bit so the carry-out falls out of the addition directly.
   assign w_full    = {1'b0, i_a} + {1'b0, i_b} + {{CHUNK{1'b0}}, i_cin};
   assign o_sum     = w_full[CHUNK-1:0];
   assign o_cout    = w_full[CHUNK];
   assign o_sum_msb = w_full[CHUNK-1];

endmodule : addsub_slice
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : seq_addsub
// Description : Multi-cycle WIDTH-bit adder/subtractor. One CHUNK-bit slice is
//               processed per RUN cycle with the carry chained in a register.
//               Subtraction is a + ~b + ~cin, so cout reads as "no borrow".
// Revision    : 1.0 - initial release
// ============================================================================
module seq_addsub
   import seq_addsub_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int NCHUNK = WIDTH / CHUNK;
   localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [IDXW-1:0] c_LAST_IDX = IDXW'(NCHUNK - 1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;        // already inverted for subtraction
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic [IDXW-1:0]  r_idx;

   logic [CHUNK-1:0] w_a_sl;
   logic [CHUNK-1:0] w_b_sl;
   logic [CHUNK-1:0] w_s_sl;
   logic             w_c;
   logic             w_s_msb;
   logic             w_accept;
   logic             w_run;
   logic             w_last;

   assign w_accept = (r_state == ST_IDLE) && start;
   assign w_run    = (r_state == ST_RUN);
   assign w_last   = (r_idx == c_LAST_IDX);

   // Present the current slice of the latched operands to the shared adder.
   assign w_a_sl = r_a[r_idx*CHUNK +: CHUNK];
   assign w_b_sl = r_b[r_idx*CHUNK +: CHUNK];

   addsub_slice #(
      .CHUNK (CHUNK)
   ) u_slice (
      .i_a       (w_a_sl),
      .i_b       (w_b_sl),
      .i_cin     (r_carry),
      .o_sum     (w_s_sl),
      .o_cout    (w_c),
      .o_sum_msb (w_s_msb)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; busy/done depend only on the state register.
   always_comb begin
      w_state_nxt = r_state;
      busy        = 1'b0;
      done        = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_state_nxt = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_nxt = ST_DONE;
         end
         ST_DONE: begin
            done        = 1'b1;
            w_state_nxt = ST_IDLE;   // start in DONE is deliberately ignored
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand capture on accept, then one slice per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a     <= '0;
         r_b     <= '0;
         r_sum   <= '0;
         r_carry <= 1'b0;
         r_cout  <= 1'b0;
         r_ovf   <= 1'b0;
         r_idx   <= '0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= sub ? ~b : b;
         r_carry <= cin ^ sub;
         r_idx   <= '0;
      end else if (w_run) begin
         r_sum[r_idx*CHUNK +: CHUNK] <= w_s_sl;
         r_carry <= w_c;
         r_idx   <= r_idx + 1'b1;
         if (w_last) begin
            // The final slice holds the word MSB, so its flags are the result flags.
            r_cout <= w_c;
            r_ovf  <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_s_msb != r_a[WIDTH-1]);
         end
      end
   end

   assign sum  = r_sum;
   assign cout = r_cout;
   assign ovf  = r_ovf;

endmodule : seq_addsub
`default_nettype wire

// File: tb/tb_seq_addsub.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_addsub
// Description : Self-checking bench for seq_addsub. Three instances (CHUNK =
//               4, 16, 1) share stimulus; results are compared against a plain
//               arithmetic model of add/subtract with carry and signed overflow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_addsub;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        sub;
   logic        cin;
   logic [15:0] a;
   logic [15:0] b;

   logic        busy_v [3];
   logic        done_v [3];
   logic [15:0] sum_v  [3];
   logic        cout_v [3];
   logic        ovf_v  [3];

   int n_checks;
   int n_pass;

   seq_addsub #(.WIDTH(16), .CHUNK(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0])
   );
   seq_addsub #(.WIDTH(16), .CHUNK(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1])
   );
   seq_addsub #(.WIDTH(16), .CHUNK(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .cin(cin), .a(a), .b(b),
      .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Number of slices (RUN cycles) for each instance.
   function automatic int nch_of(input int d);
      case (d)
         0:       return 4;
         1:       return 1;
         default: return 16;
      endcase
   endfunction

   // Reference: returns {ovf, cout, sum} from ordinary integer arithmetic.
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic ms, input logic mc);
      logic [16:0] full;
      logic        c;
      int          sr;
      if (!ms) begin
         full = {1'b0, ma} + {1'b0, mb} + {16'd0, mc};
         c    = full[16];
         sr   = int'($signed(ma)) + int'($signed(mb)) + int'(mc);
      end else begin
         full = {1'b0, ma} - {1'b0, mb} - {16'd0, mc};
         c    = ~full[16];                       // no borrow
         sr   = int'($signed(ma)) - int'($signed(mb)) - int'(mc);
      end
      return {(sr > 32767) || (sr < -32768), c, full[15:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic chk_results(input string tag, input int d, input logic [17:0] e);
      chk($sformatf("%s n%0d sum", tag, nch_of(d)), 32'(sum_v[d]), 32'(e[15:0]));
      chk($sformatf("%s n%0d cout", tag, nch_of(d)), 32'(cout_v[d]), 32'(e[16]));
      chk($sformatf("%s n%0d ovf", tag, nch_of(d)), 32'(ovf_v[d]), 32'(e[17]));
   endtask

   task automatic chk_all_zero(input string tag);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s n%0d busy", tag, nch_of(d)), 32'(busy_v[d]), 32'd0);
         chk($sformatf("%s n%0d done", tag, nch_of(d)), 32'(done_v[d]), 32'd0);
         chk_results(tag, d, 18'd0);
      end
   endtask

   // One operation on all instances: checks latency, single done pulse, results.
   task automatic do_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_,
                        input logic ts, input logic tc);
      logic [17:0] e;
      int first [3];
      int npulse [3];
      e = model(ta, tb_, ts, tc);
      @(negedge clk);
      a = ta; b = tb_; sub = ts; cin = tc; start = 1'b1;
      @(posedge clk);                            // accepting edge E0
      @(negedge clk);
      start = 1'b0;
      a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s n%0d busy", tag, nch_of(d)), 32'(busy_v[d]), 32'd1);
         first[d]  = -1;
         npulse[d] = 0;
      end
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) begin
            if (done_v[d]) begin
               npulse[d]++;
               if (first[d] < 0) begin
                  first[d] = k;
                  chk_results(tag, d, e);
               end
            end
         end
      end
      for (int d = 0; d < 3; d++) begin
         chk($sformatf("%s n%0d latency", tag, nch_of(d)), 32'(first[d]), 32'(nch_of(d)));
         chk($sformatf("%s n%0d pulses", tag, nch_of(d)), 32'(npulse[d]), 32'd1);
         chk($sformatf("%s n%0d idle", tag, nch_of(d)), 32'(busy_v[d]), 32'd0);
         chk_results({tag, " hold"}, d, e);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [17:0] e1;
      logic [17:0] e2;
      int          got;
      n_checks = 0;
      n_pass   = 0;
      rst_n = 1'b0; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_all_zero("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Directed cases, run on CHUNK = 4, 16 and 1 simultaneously.
      do_op("add1",     16'h0001, 16'h0000, 1'b0, 1'b0);
      do_op("addwrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0);
      do_op("addovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0);
      do_op("subneg",   16'h0003, 16'h0005, 1'b1, 1'b0);
      do_op("subbrw",   16'h0009, 16'h0006, 1'b1, 1'b1);
      do_op("subovf",   16'h8000, 16'h0001, 1'b1, 1'b0);
      do_op("addcin",   16'h00FF, 16'h0F00, 1'b0, 1'b1);

      for (int i = 0; i < 16; i++)
         do_op($sformatf("rand%0d", i), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));

      // start held high with operands changing every cycle (CHUNK=4 instance).
      @(negedge clk);
      a = 16'h1234; b = 16'h4321; sub = 1'b0; cin = 1'b0; start = 1'b1;
      e1 = model(16'h1234, 16'h4321, 1'b0, 1'b0);
      e2 = '0;
      @(posedge clk);                            // E0
      for (int k = 1; k <= 6; k++) begin
         @(posedge clk); #1;
         if (k == 4) begin
            chk("held done", 32'(done_v[0]), 32'd1);
            chk_results("held", 0, e1);
         end
         if (k == 5) begin
            chk("held done-to-idle busy", 32'(busy_v[0]), 32'd0);
            chk("held done-to-idle done", 32'(done_v[0]), 32'd0);
         end
         if (k == 6) chk("held reaccept busy", 32'(busy_v[0]), 32'd1);
         @(negedge clk);
         a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
         if (k == 5) e2 = model(a, b, sub, cin);
         if (k == 6) start = 1'b0;
      end
      got = 0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk); #1;
         if (done_v[0] && got == 0) begin
            got = k;
            chk_results("held second", 0, e2);
         end
      end
      chk("held second latency", 32'(got), 32'd4);
      repeat (40) @(posedge clk);

      // Asynchronous reset during the second RUN cycle.
      @(negedge clk);
      a = 16'hFFFF; b = 16'h0000; sub = 1'b0; cin = 1'b0; start = 1'b1;
      @(posedge clk);                            // E0
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);                            // now in second RUN cycle
      #2;
      rst_n = 1'b0;
      #1;
      chk_all_zero("async rst");
      @(negedge clk);
      rst_n = 1'b1;
      got = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clk); #1;
         for (int d = 0; d < 3; d++) if (done_v[d]) got++;
      end
      chk("no done after rst", 32'(got), 32'd0);
      do_op("postrst", 16'h0011, 16'h0022, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_seq_addsub
`default_nettype wire
